// File: rtl/eth_gen_pkg.sv
// Shared types and helpers for the Galapagos Ethernet frame generator.
//   ETHERTYPE_GALAPAGOS : ethertype carried in header bytes 12-13
//   HDR_BYTES           : Galapagos header length in bytes
//   state_t             : generator FSM states
//   cmd_t               : latched frame request
//   build_hdr()         : 16-byte header in wire byte order (byte 0 on bits [7:0])
package eth_gen_pkg;

  localparam logic [15:0] ETHERTYPE_GALAPAGOS = 16'h7400;
  localparam int unsigned HDR_BYTES           = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0]  dest;
    logic [15:0] len;
    logic [63:0] seed;
  } cmd_t;

  // MACs go out most-significant byte first; byte b of the header lands on bits [8b+7:8b].
  function automatic logic [127:0] build_hdr(input logic [47:0] dst,
                                             input logic [47:0] src,
                                             input logic [7:0]  dest,
                                             input logic [7:0]  src_rank);
    logic [127:0] h;
    h = '0;
    for (int b = 0; b < 6; b++) begin
      h[8*b +: 8]     = dst[8*(5-b) +: 8];
      h[8*(b+6) +: 8] = src[8*(5-b) +: 8];
    end
    h[103:96]  = ETHERTYPE_GALAPAGOS[15:8];
    h[111:104] = ETHERTYPE_GALAPAGOS[7:0];
    h[119:112] = dest;
    h[127:120] = src_rank;
    return h;
  endfunction

endpackage

// File: rtl/eth_hdr_check.sv
// Rx header checker: compares the first header beats of each incoming frame
// against the header this node expects to receive, and counts pass/fail per
// frame on tlast. Byte 15 (sender rank) is not checked. Counters saturate.
// Only compiled when ETH_FRAME_GEN_RX_CHECK_EN is defined.
//   clk, rst_n           : clock, async active-low reset
//   tdata, tlast, tvalid : rx stream (sink is always ready)
//   rx_ok, rx_err        : frame pass/fail counts
`ifdef ETH_FRAME_GEN_RX_CHECK_EN
module eth_hdr_check
  import eth_gen_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter logic [47:0] LOCAL_MAC  = 48'hfa163e55ca02,
  parameter logic [47:0] REMOTE_MAC = 48'h0cc47a88c047,
  parameter logic [7:0]  LOCAL_RANK = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] tdata,
  input  logic                  tlast,
  input  logic                  tvalid,
  output logic [15:0]           rx_ok,
  output logic [15:0]           rx_err
);

  localparam int unsigned BYTES     = DATA_WIDTH / 8;
  localparam int unsigned HDR_FLITS = HDR_BYTES / BYTES;
  localparam logic [127:0] EXP_HDR  = build_hdr(LOCAL_MAC, REMOTE_MAC, LOCAL_RANK, 8'h00);
  localparam logic [127:0] HDR_MASK = {8'h00, {120{1'b1}}};

  logic [1:0]            beat_cnt;
  logic                  match;
  logic                  in_hdr;
  logic                  beat_ok;
  logic                  hdr_done;
  logic                  frame_ok;
  logic [DATA_WIDTH-1:0] exp_beat;
  logic [DATA_WIDTH-1:0] mask_beat;

  // Per-beat header comparison and end-of-frame verdict.
  always_comb begin
    in_hdr    = 32'(beat_cnt) < HDR_FLITS;
    exp_beat  = DATA_WIDTH'(EXP_HDR >> (DATA_WIDTH * 32'(beat_cnt)));
    mask_beat = DATA_WIDTH'(HDR_MASK >> (DATA_WIDTH * 32'(beat_cnt)));
    beat_ok   = !in_hdr || (((tdata ^ exp_beat) & mask_beat) == '0);
    hdr_done  = (32'(beat_cnt) + 32'd1) >= HDR_FLITS;
    frame_ok  = match && beat_ok && hdr_done;
  end

  // Beat tracking and saturating result counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= 2'd0;
      match    <= 1'b1;
      rx_ok    <= 16'd0;
      rx_err   <= 16'd0;
    end else if (tvalid) begin
      if (tlast) begin
        beat_cnt <= 2'd0;
        match    <= 1'b1;
        if (frame_ok) begin
          if (rx_ok != 16'hffff) rx_ok <= rx_ok + 16'd1;
        end else begin
          if (rx_err != 16'hffff) rx_err <= rx_err + 16'd1;
        end
      end else begin
        if (in_hdr) beat_cnt <= beat_cnt + 2'd1;
        match <= match & beat_ok;
      end
    end
  end

endmodule
`endif

// File: rtl/eth_frame_gen.sv
// AXI-Stream Galapagos frame generator for the debug shell.
// Each accepted command emits one frame: a 16-byte header followed by a
// counter-pattern payload (64-bit lanes, little-endian). Optional rx header
// checker is enabled by defining ETH_FRAME_GEN_RX_CHECK_EN.
//   aclk, aresetn                      : clock, async active-low reset
//   cmd_valid/ready, cmd_dest/len/seed : frame request (ready only in IDLE)
//   m_axis_*                           : tx stream, byte 0 on bits [7:0]
//   s_axis_*                           : rx stream (always ready)
//   busy                               : frame in progress
//   tx_frames                          : completed frames (wraps)
//   rx_ok, rx_err                      : rx header pass/fail counts
module eth_frame_gen
  import eth_gen_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter logic [47:0] LOCAL_MAC  = 48'hfa163e55ca02,
  parameter logic [47:0] REMOTE_MAC = 48'h0cc47a88c047,
  parameter logic [7:0]  LOCAL_RANK = 8'h00,
  parameter int unsigned MAX_PAY    = 9000,
  localparam int unsigned BYTES     = DATA_WIDTH / 8
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [7:0]            cmd_dest,
  input  logic [15:0]           cmd_len,
  input  logic [63:0]           cmd_seed,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [BYTES-1:0]      m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [BYTES-1:0]      s_axis_tkeep,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic                  busy,
  output logic [31:0]           tx_frames,
  output logic [15:0]           rx_ok,
  output logic [15:0]           rx_err
);

  localparam int unsigned LANES     = BYTES / 8;
  localparam int unsigned HDR_FLITS = HDR_BYTES / BYTES;

  state_t                state, state_d;
  logic                  hdr_idx, hdr_idx_d;   // header beat currently presented
  logic [15:0]           rem, rem_d;           // payload bytes from the presented flit on
  logic [63:0]           cnt, cnt_d;           // lane-0 value of the presented payload flit
  logic [127:0]          hdr, hdr_d;
  cmd_t                  cmd_in;
  logic                  hs;
  logic                  hdr_last;
  logic [DATA_WIDTH-1:0] tdata_d;
  logic [DATA_WIDTH-1:0] pay_word;
  logic [BYTES-1:0]      tkeep_d;
  logic                  tlast_d;
  logic                  tvalid_d;

  assign hs       = m_axis_tvalid & m_axis_tready;
  assign hdr_last = (hdr_idx == 1'(HDR_FLITS - 1));

  // Incoming request with the payload length clamped.
  always_comb begin
    cmd_in.dest = cmd_dest;
    cmd_in.len  = (cmd_len > 16'(MAX_PAY)) ? 16'(MAX_PAY) : cmd_len;
    cmd_in.seed = cmd_seed;
  end

  // Next-state and datapath advance; nothing moves while the beat is stalled.
  always_comb begin
    state_d   = state;
    hdr_idx_d = hdr_idx;
    rem_d     = rem;
    cnt_d     = cnt;
    hdr_d     = hdr;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_d   = HDR;
          hdr_idx_d = 1'b0;
          rem_d     = cmd_in.len;
          cnt_d     = cmd_in.seed;
          hdr_d     = build_hdr(REMOTE_MAC, LOCAL_MAC, cmd_in.dest, LOCAL_RANK);
        end
      end
      HDR: begin
        if (hs) begin
          if (hdr_last) state_d = (rem == 16'd0) ? IDLE : PAY;
          else          hdr_idx_d = hdr_idx + 1'b1;
        end
      end
      PAY: begin
        if (hs) begin
          if (m_axis_tlast) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt + 64'(LANES);
            rem_d = rem - 16'(BYTES);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Beat content for the next cycle, derived from the next datapath state.
  always_comb begin
    tdata_d  = '0;
    tkeep_d  = '0;
    tlast_d  = 1'b0;
    tvalid_d = 1'b0;
    pay_word = '0;
    for (int k = 0; k < LANES; k++) pay_word[64*k +: 64] = cnt_d + 64'(k);
    unique case (state_d)
      HDR: begin
        tvalid_d = 1'b1;
        tdata_d  = DATA_WIDTH'(hdr_d >> (DATA_WIDTH * 32'(hdr_idx_d)));
        tkeep_d  = '1;
        tlast_d  = (rem_d == 16'd0) && (hdr_idx_d == 1'(HDR_FLITS - 1));
      end
      PAY: begin
        tvalid_d = 1'b1;
        tlast_d  = rem_d <= 16'(BYTES);
        for (int b = 0; b < BYTES; b++) begin
          if (16'(b) < rem_d) begin
            tkeep_d[b]        = 1'b1;
            tdata_d[8*b +: 8] = pay_word[8*b +: 8];
          end
        end
      end
      default: ;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= IDLE;
      hdr_idx       <= 1'b0;
      rem           <= 16'd0;
      cnt           <= 64'd0;
      hdr           <= '0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
      cmd_ready     <= 1'b1;
      busy          <= 1'b0;
      tx_frames     <= 32'd0;
    end else begin
      state         <= state_d;
      hdr_idx       <= hdr_idx_d;
      rem           <= rem_d;
      cnt           <= cnt_d;
      hdr           <= hdr_d;
      m_axis_tdata  <= tdata_d;
      m_axis_tkeep  <= tkeep_d;
      m_axis_tlast  <= tlast_d;
      m_axis_tvalid <= tvalid_d;
      cmd_ready     <= (state_d == IDLE);
      busy          <= (state_d != IDLE);
      if (hs && m_axis_tlast) tx_frames <= tx_frames + 32'd1;
    end
  end

  assign s_axis_tready = 1'b1;

`ifdef ETH_FRAME_GEN_RX_CHECK_EN
  eth_hdr_check #(
    .DATA_WIDTH (DATA_WIDTH),
    .LOCAL_MAC  (LOCAL_MAC),
    .REMOTE_MAC (REMOTE_MAC),
    .LOCAL_RANK (LOCAL_RANK)
  ) u_hdr_check (
    .clk    (aclk),
    .rst_n  (aresetn),
    .tdata  (s_axis_tdata),
    .tlast  (s_axis_tlast),
    .tvalid (s_axis_tvalid),
    .rx_ok  (rx_ok),
    .rx_err (rx_err)
  );
  logic unused_rx_keep;
  assign unused_rx_keep = ^s_axis_tkeep;
`else
  logic unused_rx;
  assign unused_rx = ^{s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid};
  assign rx_ok     = 16'd0;
  assign rx_err    = 16'd0;
`endif

endmodule

// File: tb/tb_eth_frame_gen.sv
`timescale 1ns/1ps
module tb_eth_frame_gen;

  localparam int unsigned DW    = 64;
  localparam int unsigned BY    = DW / 8;
  localparam int unsigned HF    = 16 / BY;
  localparam logic [47:0] LMAC  = 48'hfa163e55ca02;
  localparam logic [47:0] RMAC  = 48'h0cc47a88c047;
  localparam logic [7:0]  LRANK = 8'h00;
  localparam int          MAXP  = 9000;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [7:0]    cmd_dest = '0;
  logic [15:0]   cmd_len = '0;
  logic [63:0]   cmd_seed = '0;
  logic [DW-1:0] m_axis_tdata;
  logic [BY-1:0] m_axis_tkeep;
  logic          m_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [BY-1:0] s_axis_tkeep = '0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          busy;
  logic [31:0]   tx_frames;
  logic [15:0]   rx_ok, rx_err;

  eth_frame_gen #(.DATA_WIDTH(DW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dest(cmd_dest),
    .cmd_len(cmd_len), .cmd_seed(cmd_seed),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .busy(busy), .tx_frames(tx_frames), .rx_ok(rx_ok), .rx_err(rx_err)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [DW-1:0] d;
    logic [BY-1:0] k;
    logic          l;
  } beat_t;

  beat_t         exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            frames_exp = 0;
  int            beat_in_frame = 0;
  int            last_frame_beats = 0;
  int            accepts = 0;
  int            rx_ok_exp = 0;
  int            rx_err_exp = 0;
  logic          cap_first = 1'b0;
  logic          ready_rand = 1'b0;
  logic [DW-1:0] first_beat_data = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Byte idx of the frame on the wire, straight from the header/payload rules.
  function automatic logic [7:0] tx_byte(input logic [7:0] dest, input logic [63:0] seed, input int idx);
    logic [47:0] m;
    logic [63:0] w;
    if (idx < 6) begin
      m = RMAC;
      return 8'(m >> (8 * (5 - idx)));
    end else if (idx < 12) begin
      m = LMAC;
      return 8'(m >> (8 * (11 - idx)));
    end else if (idx == 12) return 8'h74;
    else if (idx == 13) return 8'h00;
    else if (idx == 14) return dest;
    else if (idx == 15) return LRANK;
    w = seed + 64'((idx - 16) / 8);
    return 8'(w >> (8 * ((idx - 16) % 8)));
  endfunction

  task automatic push_frame(input logic [7:0] dest, input int len, input logic [63:0] seed);
    int    plen, total, nfl, idx;
    beat_t bt;
    plen  = (len > MAXP) ? MAXP : len;
    total = 16 + plen;
    nfl   = (total + BY - 1) / BY;
    for (int f = 0; f < nfl; f++) begin
      bt.d = '0;
      bt.k = '0;
      for (int b = 0; b < BY; b++) begin
        idx = f * BY + b;
        if (idx < total) begin
          bt.d[8*b +: 8] = tx_byte(dest, seed, idx);
          bt.k[b]        = 1'b1;
        end
      end
      bt.l = (f == nfl - 1);
      exp_q.push_back(bt);
    end
  endtask

  // Per-cycle compare against the model, sampled on the falling edge.
  task automatic monitor();
    logic          pv, pl, busy_m;
    logic [DW-1:0] pd;
    logic [BY-1:0] pk;
    beat_t         e;
    pv = 1'b0; pl = 1'b0; pd = '0; pk = '0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        exp_q.delete();
        frames_exp    = 0;
        beat_in_frame = 0;
        pv            = 1'b0;
      end else begin
        busy_m = (exp_q.size() != 0);
        chk("cmd_ready", cmd_ready, !busy_m);
        chk("busy", busy, busy_m);
        chk("tvalid", m_axis_tvalid, busy_m);
        chk("tx_frames", tx_frames, frames_exp);
        if (pv) begin
          chk("stall_data", m_axis_tdata, pd);
          chk("stall_keep", m_axis_tkeep, pk);
          chk("stall_last", m_axis_tlast, pl);
        end
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL beat: got unexpected beat %0h, required none", m_axis_tdata);
          end else begin
            e = exp_q.pop_front();
            chk("tdata", m_axis_tdata, e.d);
            chk("tkeep", m_axis_tkeep, e.k);
            chk("tlast", m_axis_tlast, e.l);
            if (cap_first) begin
              first_beat_data = m_axis_tdata;
              cap_first       = 1'b0;
            end
            beat_in_frame++;
            if (e.l) begin
              frames_exp++;
              last_frame_beats = beat_in_frame;
              beat_in_frame    = 0;
            end
          end
        end
        pv = m_axis_tvalid && !m_axis_tready;
        pd = m_axis_tdata;
        pk = m_axis_tkeep;
        pl = m_axis_tlast;
        if (cmd_valid && cmd_ready) begin
          push_frame(cmd_dest, int'(cmd_len), cmd_seed);
          accepts++;
        end
      end
    end
  endtask

  task automatic tready_drv();
    forever begin
      @(posedge aclk);
      #1;
      m_axis_tready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  task automatic send_cmd(input logic [7:0] dest, input int len, input logic [63:0] seed);
    int n0, n;
    @(posedge aclk);
    #1;
    cmd_dest  = dest;
    cmd_len   = 16'(len);
    cmd_seed  = seed;
    cmd_valid = 1'b1;
    n0 = accepts;
    n  = 0;
    while (accepts == n0 && n < 20000) begin
      @(posedge aclk);
      n++;
    end
    #1;
    cmd_valid = 1'b0;
    if (accepts == n0) begin
      checks++;
      errors++;
      $display("FAIL cmd_accept: got no accept after %0d cycles, required accept", n);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 30000) begin
      @(negedge aclk);
      #1;
      n++;
    end
    checks++;
    if (n >= 30000) begin
      errors++;
      $display("FAIL wait_idle: got frame pending after %0d cycles, required done", n);
    end
    repeat (2) @(negedge aclk);
  endtask

  // Rx frame with the header this node expects; bad flips a src MAC byte.
  task automatic rx_frame(input logic bad, input int nbeats);
    logic [47:0] m;
    logic [7:0]  bv;
    int          idx;
    for (int bt = 0; bt < nbeats; bt++) begin
      @(posedge aclk);
      #1;
      for (int j = 0; j < BY; j++) begin
        idx = bt * BY + j;
        if (idx < 6) begin
          m = LMAC; bv = 8'(m >> (8 * (5 - idx)));
        end else if (idx < 12) begin
          m = RMAC; bv = 8'(m >> (8 * (11 - idx)));
        end else if (idx == 12) bv = 8'h74;
        else if (idx == 13) bv = 8'h00;
        else if (idx == 14) bv = LRANK;
        else bv = 8'($urandom);
        if (bad && idx == 6) bv = bv ^ 8'h01;
        s_axis_tdata[8*j +: 8] = bv;
      end
      s_axis_tkeep  = '1;
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = (bt == nbeats - 1);
    end
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
`ifdef ETH_FRAME_GEN_RX_CHECK_EN
    if (!bad && nbeats >= HF) rx_ok_exp++;
    else rx_err_exp++;
`endif
  endtask

  initial begin
    int n, f0, a0, len;
    logic [63:0] seed;
    fork
      monitor();
      tready_drv();
    join_none

    // Reset state
    repeat (3) @(posedge aclk);
    #2;
    chk("rst_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_tdata", m_axis_tdata, '0);
    chk("rst_tkeep", m_axis_tkeep, '0);
    chk("rst_tlast", m_axis_tlast, 1'b0);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_s_tready", s_axis_tready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tx_frames", tx_frames, 32'd0);
    chk("rst_rx_ok", rx_ok, 16'd0);
    chk("rst_rx_err", rx_err, 16'd0);
    @(negedge aclk);
    aresetn = 1'b1;

    // Hand-computed header/payload bytes pin the model
    chk("pin_byte0", tx_byte(8'h05, 64'h1000, 0), 8'h0c);
    chk("pin_byte7", tx_byte(8'h05, 64'h1000, 7), 8'h16);
    chk("pin_byte14", tx_byte(8'h05, 64'h1000, 14), 8'h05);
    chk("pin_byte17", tx_byte(8'h05, 64'h1000, 17), 8'h10);
    chk("pin_byte24", tx_byte(8'h05, 64'h1000, 24), 8'h01);

    // T1: basic frame
    cap_first = 1'b1;
    send_cmd(8'h05, 12, 64'h1000);
    wait_idle();
    chk("t1_first_beat", first_beat_data[63:0], 64'h16fa47c0887ac40c);
    chk("t1_beats", last_frame_beats, (28 + BY - 1) / BY);
    chk("t1_frames", tx_frames, 32'd1);

    // T2: zero-length payload
    send_cmd(8'h09, 0, 64'h55);
    wait_idle();
    chk("t2_beats", last_frame_beats, HF);
    chk("t2_frames", tx_frames, 32'd2);

    // T3: random backpressure
    ready_rand = 1'b1;
    send_cmd(8'h05, 64, 64'h1000);
    wait_idle();
    ready_rand = 1'b0;
    chk("t3_beats", last_frame_beats, (80 + BY - 1) / BY);

    // T4: clamp and held cmd_valid
    @(posedge aclk);
    #1;
    a0 = accepts;
    f0 = frames_exp;
    cmd_dest = 8'h03; cmd_len = 16'd20000; cmd_seed = 64'h0123_4567_89ab_cdef;
    cmd_valid = 1'b1;
    n = 0;
    while (accepts == a0 && n < 1000) begin @(posedge aclk); n++; end
    #1;
    cmd_len = 16'd8;
    n = 0;
    while (frames_exp == f0 && n < 5000) begin @(negedge aclk); #2; n++; end
    chk("t4_beats", last_frame_beats, (16 + MAXP + BY - 1) / BY);
    n = 0;
    while (accepts < a0 + 2 && n < 1000) begin @(posedge aclk); n++; end
    #1;
    cmd_valid = 1'b0;
    wait_idle();
    chk("t4_accepts", accepts - a0, 2);
    chk("t4_second_beats", last_frame_beats, (24 + BY - 1) / BY);

    // T5: reset mid-payload
    send_cmd(8'h07, 64, 64'hdead_0000);
    n = 0;
    while (beat_in_frame != HF + 3 && n < 200) begin @(negedge aclk); #2; n++; end
    chk("t5_reached_beat3", beat_in_frame, HF + 3);
    aresetn = 1'b0;
    #1;
    chk("t5_tvalid_async", m_axis_tvalid, 1'b0);
    chk("t5_busy_async", busy, 1'b0);
    chk("t5_cmd_ready_async", cmd_ready, 1'b1);
    repeat (2) @(negedge aclk);
    chk("t5_frames_in_reset", tx_frames, 32'd0);
    aresetn = 1'b1;
    send_cmd(8'h08, 33, 64'h77);
    wait_idle();
    chk("t5_frames_after", tx_frames, 32'd1);
    chk("t5_beats_after", last_frame_beats, (49 + BY - 1) / BY);

    // Randomized back-to-back frames with random backpressure
    ready_rand = 1'b1;
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 5))
        0: len = 0;
        1: len = BY - 1;
        2: len = BY;
        3: len = BY + 1;
        default: len = $urandom_range(1, 300);
      endcase
      seed = (i == 0) ? 64'hffff_ffff_ffff_fffd : {$urandom, $urandom};
      send_cmd(8'($urandom), len, seed);
    end
    wait_idle();
    ready_rand = 1'b0;
    chk("rand_frames", tx_frames, 32'd31);

    // Rx checker traffic
    rx_frame(1'b0, HF + 3);
    rx_frame(1'b1, HF + 2);
    rx_frame(1'b0, 1);
    repeat (3) @(negedge aclk);
    chk("rx_s_tready", s_axis_tready, 1'b1);
    chk("rx_ok", rx_ok, rx_ok_exp);
    chk("rx_err", rx_err, rx_err_exp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
